pipe_adder_sub: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit ripple full adder.
- Computes A+B+cin or A-B-cin on WIDTH-bit operands, splitting the carry chain into CHUNK-bit slices with one register stage per slice.
- Valid/ready handshake on both sides, with global stall on output backpressure.
- Sits between operand-fetch logic and a result sink in the datapath.

---
 rtl/pipe_adder_pkg.sv | 15 +
 rtl/pipe_adder_sub_adder_stage.sv | 26 ++
 rtl/pipe_adder_sub.sv | 109 ++++++++++
 tb/tb_pipe_adder_sub.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding,
// default geometry and the derived stage count.
package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int num_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipe_adder_sub_adder_stage.sv
// One CHUNK-wide combinational ripple slice. Also exposes the carry into
// the slice MSB so the top stage can derive signed overflow.
module adder_stage #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipe_adder_sub.sv
// Pipelined WIDTH-bit adder/subtractor, one register stage per CHUNK-bit
// carry slice, with valid/ready handshake and global stall on backpressure.
module pipe_adder_sub
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = num_stages(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  logic             advance;

  logic             valid_reg [STAGES];
  logic [WIDTH-1:0] sum_reg   [STAGES];
  logic [WIDTH-1:0] a_reg     [STAGES];
  logic [WIDTH-1:0] b_reg     [STAGES];
  logic             carry_reg [STAGES];
  logic             ovf_reg;
  logic             zero_reg;

  logic             valid_in   [STAGES];
  logic [WIDTH-1:0] a_in       [STAGES];
  logic [WIDTH-1:0] b_in       [STAGES];
  logic [WIDTH-1:0] sum_in     [STAGES];
  logic             carry_in   [STAGES];
  logic [WIDTH-1:0] sum_next   [STAGES];
  logic             carry_next [STAGES];
  logic             msb_carry  [STAGES];
  logic [CHUNK-1:0] slice_sum  [STAGES];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      // Subtraction is folded in here: B and the borrow are inverted once.
      assign valid_in[gi] = in_valid;
      assign a_in[gi]     = A;
      assign b_in[gi]     = (op == OP_SUB) ? ~B : B;
      assign carry_in[gi] = (op == OP_SUB) ? ~cin : cin;
      assign sum_in[gi]   = '0;
    end else begin : g_chain
      assign valid_in[gi] = valid_reg[gi-1];
      assign a_in[gi]     = a_reg[gi-1];
      assign b_in[gi]     = b_reg[gi-1];
      assign carry_in[gi] = carry_reg[gi-1];
      assign sum_in[gi]   = sum_reg[gi-1];
    end

    adder_stage #(.CHUNK(CHUNK)) u_stage (
      .a     (a_in[gi][gi*CHUNK +: CHUNK]),
      .b     (b_in[gi][gi*CHUNK +: CHUNK]),
      .ci    (carry_in[gi]),
      .s     (slice_sum[gi]),
      .co    (carry_next[gi]),
      .c_msb (msb_carry[gi])
    );

    // Bits at and above this slice are still zero in the skewed sum.
    assign sum_next[gi] = sum_in[gi] | (WIDTH'(slice_sum[gi]) << (gi*CHUNK));
  end

  assign advance   = !valid_reg[LAST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_reg[LAST];
  assign S         = sum_reg[LAST];
  assign cout      = carry_reg[LAST];
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        sum_reg[k]   <= '0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
        carry_reg[k] <= 1'b0;
      end
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= valid_in[k];
        sum_reg[k]   <= sum_next[k];
        a_reg[k]     <= a_in[k];
        b_reg[k]     <= b_in[k];
        carry_reg[k] <= carry_next[k];
      end
      ovf_reg  <= carry_next[LAST] ^ msb_carry[LAST];
      zero_reg <= (sum_next[LAST] == '0);
    end
  end

endmodule

// File: tb/tb_pipe_adder_sub.sv
// Scoreboard bench for pipe_adder_sub at WIDTH=16, CHUNK=4: expected
// results are queued on accept and compared on each output transfer.
module tb_pipe_adder_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        cin = 1'b0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] S;
  logic        cout;
  logic        ovf;
  logic        zero;

  pipe_adder_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   cyc      = 0;
  logic chk_lat  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic o, input int acc);
    exp_t        m;
    logic [15:0] bb;
    logic        cc;
    logic [16:0] full;
    bb    = o ? ~b : b;
    cc    = o ? ~c : c;
    full  = {1'b0, a} + {1'b0, bb} + {16'd0, cc};
    m.s   = full[15:0];
    m.co  = full[16];
    m.ov  = (a[15] == bb[15]) && (full[15] != a[15]);
    m.z   = (full[15:0] == 16'd0);
    m.acc = acc;
    return m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are judged mid-cycle; they complete on the following edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("S", {16'd0, S}, {16'd0, e.s});
        check("cout", {31'd0, cout}, {31'd0, e.co});
        check("ovf", {31'd0, ovf}, {31'd0, e.ov});
        check("zero", {31'd0, zero}, {31'd0, e.z});
        if (chk_lat) check("latency", cyc - e.acc, 32'd4);
        n_out++;
        $display("out  S=%h cout=%b ovf=%b zero=%b cyc=%0d", S, cout, ovf, zero, cyc);
      end
    end
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(model(A, B, cin, op, cyc));
      $display("in   A=%h B=%h cin=%b op=%b cyc=%0d", A, B, cin, op, cyc);
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic o);
    int w;
    w        = 0;
    A        = a;
    B        = b;
    cin      = c;
    op       = o;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w        = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic [15:0] hold_s;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_S", {16'd0, S}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic cases at full rate.
    chk_lat = 1'b1;
    send(16'h0003, 16'h0005, 1'b0, 1'b0);
    idle();
    drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    drain();

    // Bubbles: every other cycle carries a beat.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(16'h1000 + 16'(i), 16'(i), 1'b0, 1'b0);
      else idle();
    end
    drain();

    // Backpressure: 3-cycle stall after the first result appears.
    chk_lat = 1'b0;
    base    = n_out;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(16'(i), 16'(2 * i), 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
          @(posedge clk);
          #1;
          w++;
        end
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        hold_s    = S;
        repeat (3) begin
          @(negedge clk);
          check("bp_hold_S", {16'd0, S}, {16'd0, hold_s});
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - base, 32'd6);

    // Reset with three beats in flight.
    chk_lat = 1'b1;
    send(16'h0011, 16'h0022, 1'b0, 1'b0);
    send(16'h0033, 16'h0044, 1'b0, 1'b0);
    send(16'h0055, 16'h0066, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_S", {16'd0, S}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_hold", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = n_out;
    send(16'h0100, 16'h0200, 1'b0, 1'b0);
    idle();
    drain();
    check("post_rst_count", n_out - base, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
